// File: rtl/code_lock_pkg.sv
// Shared state encoding, BCD constants and key indices for the code-lock controller.
package code_lock_pkg;

   typedef enum logic [2:0] {
      ST_ENTRY = 3'd0,
      ST_CHECK = 3'd1,
      ST_OPEN  = 3'd2,
      ST_SET   = 3'd3,
      ST_STORE = 3'd4,
      ST_FAIL  = 3'd5,
      ST_ALARM = 3'd6
   } state_e;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   localparam int KEY_INC = 0;
   localparam int KEY_OK  = 1;

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d == BCD_MAX) ? '0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared dwell timer for FAIL and ALARM: loads duration-1 on clear, counts down while enabled.
module lock_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic [31:0] duration,
   output logic        done
);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = duration - 32'd1;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal count marks the last cycle of the dwell.
   assign done = enable && (cnt_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Code-lock sequencing FSM: BCD digit entry from debounced key pulses, compare,
// unlock, password change, timed fail display and alarm lockout.
//
//   state    | meaning
//   ENTRY    | editing code digits while locked
//   CHECK    | one cycle: compare entry with stored password
//   OPEN     | unlocked; OK relocks, INC starts a password change
//   SET      | editing a new password
//   STORE    | one cycle: commit new password
//   FAIL     | wrong code shown for FAIL_CYCLES, keys ignored
//   ALARM    | lockout for ALARM_CYCLES after MAX_TRIES failures, keys ignored
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int                  DIGITS       = 4,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234,
   parameter int                  MAX_TRIES    = 3,
   parameter int unsigned         FAIL_CYCLES  = 32'd12_000_000,
   parameter int unsigned         ALARM_CYCLES = 32'd60_000_000
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [1:0]                                  key_pulse,
   output logic [3:0]                                  cur_digit,
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
   output logic [4*DIGITS-1:0]                         entry_code,
   output logic                                        unlocked,
   output logic                                        setting,
   output logic                                        fail,
   output logic                                        alarm,
   output logic [1:0]                                  err_cnt
);

   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CODE_W = BCD_W * DIGITS;
   localparam logic [1:0] ERR_MAX = 2'(MAX_TRIES);

   state_e             state_q, state_d;
   logic [CODE_W-1:0]  pwd_q, pwd_d;
   logic [CODE_W-1:0]  entry_q, entry_d;
   logic [BCD_W-1:0]   cur_q, cur_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         err_q, err_d;
   logic [1:0]         err_inc;
   logic               tmr_clear, tmr_en, tmr_done;
   logic [31:0]        tmr_dur;

   assign err_inc = (err_q == ERR_MAX) ? err_q : err_q + 2'd1;

   always_comb begin
      state_d = state_q;
      pwd_d   = pwd_q;
      entry_d = entry_q;
      cur_d   = cur_q;
      idx_d   = idx_q;
      err_d   = err_q;

      case (state_q)
         ST_ENTRY, ST_SET: begin
            if (key_pulse[KEY_OK]) begin
               entry_d[BCD_W*(DIGITS-1-int'(idx_q)) +: BCD_W] = cur_q;
               idx_d = idx_q + IDX_W'(1);
               cur_d = '0;
               if (idx_q == IDX_W'(DIGITS-1)) begin
                  state_d = (state_q == ST_ENTRY) ? ST_CHECK : ST_STORE;
               end
            end else if (key_pulse[KEY_INC]) begin
               cur_d = bcd_inc(cur_q);
            end
         end
         ST_CHECK: begin
            if (entry_q == pwd_q) begin
               state_d = ST_OPEN;
               err_d   = '0;
            end else begin
               err_d   = err_inc;
               state_d = (err_inc == ERR_MAX) ? ST_ALARM : ST_FAIL;
            end
         end
         ST_OPEN: begin
            if (key_pulse[KEY_OK]) begin
               state_d = ST_ENTRY;
            end else if (key_pulse[KEY_INC]) begin
               state_d = ST_SET;
            end
         end
         ST_STORE: begin
            pwd_d   = entry_q;
            state_d = ST_ENTRY;
         end
         ST_FAIL: begin
            if (tmr_done) begin
               state_d = ST_ENTRY;
            end
         end
         ST_ALARM: begin
            if (tmr_done) begin
               state_d = ST_ENTRY;
               err_d   = '0;
            end
         end
         default: begin
            state_d = ST_ENTRY;
         end
      endcase

      // Both editing states start from a blank entry.
      if ((state_d != state_q) && ((state_d == ST_ENTRY) || (state_d == ST_SET))) begin
         entry_d = '0;
         idx_d   = '0;
         cur_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_ENTRY;
         pwd_q   <= DEFAULT_CODE;
         entry_q <= '0;
         cur_q   <= '0;
         idx_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         pwd_q   <= pwd_d;
         entry_q <= entry_d;
         cur_q   <= cur_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Duration follows the state being entered so the load lands with the transition.
   assign tmr_clear = (state_d != state_q);
   assign tmr_en    = (state_q == ST_FAIL) || (state_q == ST_ALARM);
   assign tmr_dur   = (state_d == ST_ALARM) ? ALARM_CYCLES : FAIL_CYCLES;

   lock_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .enable   (tmr_en),
      .duration (tmr_dur),
      .done     (tmr_done)
   );

   assign cur_digit  = cur_q;
   assign digit_idx  = idx_q;
   assign entry_code = entry_q;
   assign err_cnt    = err_q;
   assign unlocked   = (state_q == ST_OPEN);
   assign setting    = (state_q == ST_SET);
   assign fail       = (state_q == ST_FAIL);
   assign alarm      = (state_q == ST_ALARM);

endmodule
